// File: rtl/qam16_pkg.sv
// Shared 16-QAM definitions: symbol/level widths and the 4-ASK level constants
// used by both the transmit deserializer and the receive-side slicer.
package qam16_pkg;

  localparam int unsigned SYM_W        = 2;
  localparam int unsigned BITS_PER_SYM = 4;
  localparam int unsigned LEVEL_W      = 18;
  localparam int unsigned CNT_W        = $clog2(BITS_PER_SYM);

  typedef logic [SYM_W-1:0]          sym_code_t;
  typedef logic signed [LEVEL_W-1:0] level_t;

  // Levels in signed 1s17 fixed point.
  localparam level_t LVL_M3 = 18'h28000;  // -0.75
  localparam level_t LVL_M1 = 18'h38000;  // -0.25
  localparam level_t LVL_P1 = 18'h08000;  // +0.25
  localparam level_t LVL_P3 = 18'h18000;  // +0.75

  function automatic level_t code_to_level(input sym_code_t code);
    level_t level;
    unique case (code)
      2'b00:   level = LVL_M3;
      2'b01:   level = LVL_M1;
      2'b10:   level = LVL_P1;
      default: level = LVL_P3;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/ask4_level_map.sv
// Combinational 4-ASK mapper: 2-bit slicer code to signed 1s17 level.
module ask4_level_map
  import qam16_pkg::*;
(
  input  logic [SYM_W-1:0]          code,
  output logic signed [LEVEL_W-1:0] level
);

  always_comb begin
    level = code_to_level(code);
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Serial bit stream to 16-QAM symbol deserializer (wire order Q1, Q0, I1, I0).
// Define S2P_LEVEL_MAP_EN to add registered 4-ASK level outputs map_I/map_Q.
module serial_to_parallel
  import qam16_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sam_clk_en,
  input  logic                      serial_in,
  input  logic                      align,
  output logic [SYM_W-1:0]          sym_I,
  output logic [SYM_W-1:0]          sym_Q,
  output logic                      sym_valid,
`ifdef S2P_LEVEL_MAP_EN
  output logic signed [LEVEL_W-1:0] map_I,
  output logic signed [LEVEL_W-1:0] map_Q,
`endif
  output logic [CNT_W-1:0]          bit_phase
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(BITS_PER_SYM - 1);

  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_SYM-2:0] shift_q, shift_d;
  sym_code_t               sym_i_q, sym_i_d;
  sym_code_t               sym_q_q, sym_q_d;
  logic                    valid_q, valid_d;
  logic                    load_sym;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sym_i_d   = sym_i_q;
    sym_q_d   = sym_q_q;
    valid_d   = 1'b0;
    load_sym  = 1'b0;
    if (align) begin
      // Realignment drops the partial symbol; an accompanying bit becomes Q[1].
      shift_d = '0;
      if (sam_clk_en) begin
        shift_d[0] = serial_in;
        bit_cnt_d  = CNT_W'(1);
      end else begin
        bit_cnt_d  = '0;
      end
    end else if (sam_clk_en) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (bit_cnt_q == LastBit) begin
        load_sym = 1'b1;
        valid_d  = 1'b1;
        sym_q_d  = {shift_q[0], shift_q[1]};
        sym_i_d  = {shift_q[2], serial_in};
      end else begin
        shift_d[bit_cnt_q] = serial_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sym_i_q   <= '0;
      sym_q_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sym_i_q   <= sym_i_d;
      sym_q_q   <= sym_q_d;
      valid_q   <= valid_d;
    end
  end

`ifdef S2P_LEVEL_MAP_EN
  level_t map_i_d, map_q_d;
  level_t map_i_q, map_q_q;

  // Mapped from the next-state codes so levels load on the same edge as sym_I/sym_Q.
  ask4_level_map u_map_i (
    .code  (sym_i_d),
    .level (map_i_d)
  );

  ask4_level_map u_map_q (
    .code  (sym_q_d),
    .level (map_q_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      map_i_q <= '0;
      map_q_q <= '0;
    end else if (load_sym) begin
      map_i_q <= map_i_d;
      map_q_q <= map_q_d;
    end
  end

  assign map_I = map_i_q;
  assign map_Q = map_q_q;
`else
  logic unused_load_sym;
  assign unused_load_sym = load_sym;
`endif

  assign sym_I     = sym_i_q;
  assign sym_Q     = sym_q_q;
  assign sym_valid = valid_q;
  assign bit_phase = bit_cnt_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel; define S2P_LEVEL_MAP_EN to also check map_I/map_Q.
module tb_serial_to_parallel;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                sam_clk_en = 1'b0;
  logic                serial_in = 1'b0;
  logic                align = 1'b0;
  logic [1:0]          sym_I, sym_Q, bit_phase;
  logic                sym_valid;
`ifdef S2P_LEVEL_MAP_EN
  logic signed [17:0]  map_I, map_Q;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int first_valid_cyc = 0;
  int last_valid_cyc = 0;
  logic prev_valid = 1'b0;

  serial_to_parallel dut (
    .clk        (clk),
    .reset      (reset),
    .sam_clk_en (sam_clk_en),
    .serial_in  (serial_in),
    .align      (align),
    .sym_I      (sym_I),
    .sym_Q      (sym_Q),
    .sym_valid  (sym_valid),
`ifdef S2P_LEVEL_MAP_EN
    .map_I      (map_I),
    .map_Q      (map_Q),
`endif
    .bit_phase  (bit_phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sym_valid must never be high on two consecutive cycles.
  always @(negedge clk) begin
    if (!reset && sym_valid) begin
      check("valid_not_consecutive", 32'(prev_valid), 32'd0);
      if (valid_cnt == 0) first_valid_cyc = cyc;
      last_valid_cyc = cyc;
      valid_cnt++;
    end
    prev_valid = sym_valid;
  end

  task automatic send_bit(input logic b, input logic al);
    serial_in  = b;
    align      = al;
    sam_clk_en = 1'b1;
    @(posedge clk);
    #1;
    sam_clk_en = 1'b0;
    align      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_nibble(input logic [3:0] bits);
    for (int k = 3; k >= 0; k--) send_bit(bits[k], 1'b0);
  endtask

  int base;
  logic [1:0] ri, rq;
  logic [3:0] nib;

  initial begin
    // Reset state
    idle(2);
    check("rst_sym_I", 32'(sym_I), 32'd0);
    check("rst_sym_Q", 32'(sym_Q), 32'd0);
    check("rst_valid", 32'(sym_valid), 32'd0);
    check("rst_phase", 32'(bit_phase), 32'd0);
`ifdef S2P_LEVEL_MAP_EN
    check("rst_map_I", 32'(map_I), 32'd0);
    check("rst_map_Q", 32'(map_Q), 32'd0);
`endif
    reset = 1'b0;
    idle(1);

    // Basic symbol 1,0,0,1
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    check("t1_valid_pre", 32'(sym_valid), 32'd0);
    check("t1_phase_pre", 32'(bit_phase), 32'd3);
    send_bit(1'b1, 1'b0);
    check("t1_valid", 32'(sym_valid), 32'd1);
    check("t1_sym_Q", 32'(sym_Q), 32'd2);
    check("t1_sym_I", 32'(sym_I), 32'd1);
    check("t1_phase", 32'(bit_phase), 32'd0);
`ifdef S2P_LEVEL_MAP_EN
    check("t1_map_Q", 32'(map_Q), 32'(18'h08000));
    check("t1_map_I", 32'(map_I), 32'(18'h38000));
`endif
    idle(1);
    check("t1_valid_post", 32'(sym_valid), 32'd0);
    check("t1_sym_Q_hold", 32'(sym_Q), 32'd2);
    check("t1_sym_I_hold", 32'(sym_I), 32'd1);

    // Enable every 4th clk, stream 0000 1111
    base = valid_cnt;
    valid_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      send_bit(k >= 4, 1'b0);
      if (k == 3) begin
        check("t2_sym_Q0", 32'(sym_Q), 32'd0);
        check("t2_sym_I0", 32'(sym_I), 32'd0);
      end
      idle(3);
    end
    check("t2_pulses", 32'(valid_cnt), 32'd2);
    check("t2_spacing", 32'(last_valid_cyc - first_valid_cyc), 32'd16);
    check("t2_sym_Q", 32'(sym_Q), 32'd3);
    check("t2_sym_I", 32'(sym_I), 32'd3);
`ifdef S2P_LEVEL_MAP_EN
    check("t2_map_Q", 32'(map_Q), 32'(18'h18000));
    check("t2_map_I", 32'(map_I), 32'(18'h18000));
`endif

    // Two bits, then realign with bit 0, then 1,1,1
    valid_cnt = 0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check("t3_phase_align", 32'(bit_phase), 32'd1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t3_valid", 32'(sym_valid), 32'd1);
    idle(2);
    check("t3_pulses", 32'(valid_cnt), 32'd1);
    check("t3_sym_Q", 32'(sym_Q), 32'd1);
    check("t3_sym_I", 32'(sym_I), 32'd3);

    // Align while bit_cnt==3 suppresses the symbol
    valid_cnt = 0;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("t4_phase_pre", 32'(bit_phase), 32'd3);
    send_bit(1'b1, 1'b1);
    check("t4_valid", 32'(sym_valid), 32'd0);
    check("t4_phase", 32'(bit_phase), 32'd1);
    check("t4_sym_Q_hold", 32'(sym_Q), 32'd1);
    // Align without an enable returns to phase 0
    align = 1'b1;
    idle(1);
    align = 1'b0;
    check("t4_phase_noen", 32'(bit_phase), 32'd0);
    check("t4_pulses", 32'(valid_cnt), 32'd0);

    // Reset mid-symbol, then 1,1,0,0
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    reset = 1'b1;
    idle(1);
    check("t5_rst_sym_I", 32'(sym_I), 32'd0);
    check("t5_rst_sym_Q", 32'(sym_Q), 32'd0);
    check("t5_rst_phase", 32'(bit_phase), 32'd0);
    check("t5_rst_valid", 32'(sym_valid), 32'd0);
    reset = 1'b0;
    send_nibble(4'b1100);
    check("t5_valid", 32'(sym_valid), 32'd1);
    check("t5_sym_Q", 32'(sym_Q), 32'd3);
    check("t5_sym_I", 32'(sym_I), 32'd0);
`ifdef S2P_LEVEL_MAP_EN
    check("t5_map_Q", 32'(map_Q), 32'(18'h18000));
    check("t5_map_I", 32'(map_I), 32'(18'h28000));
`endif
    idle(1);

    // Back-to-back random loopback: serialize Q1,Q0,I1,I0 and compare recovered codes
    valid_cnt = 0;
    for (int s = 0; s < 1000; s++) begin
      ri  = 2'($urandom_range(0, 3));
      rq  = 2'($urandom_range(0, 3));
      nib = {rq, ri};
      send_nibble(nib);
      if (sym_valid !== 1'b1 || sym_I !== ri || sym_Q !== rq) begin
        check("lb_valid", 32'(sym_valid), 32'd1);
        check("lb_sym_I", 32'(sym_I), 32'(ri));
        check("lb_sym_Q", 32'(sym_Q), 32'(rq));
      end else begin
        checks++;
      end
    end
    idle(1);
    check("lb_pulses", 32'(valid_cnt), 32'd1000);
    check("lb_spacing", 32'(last_valid_cyc - first_valid_cyc), 32'd3996);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

Transmit-side bit-stream deserializer. Consumes one serial bit per sample-clock enable and assembles every four bits into one 16-QAM symbol: a 2-bit in-phase and a 2-bit quadrature slicer code. Bit order on the wire is Q[1], Q[0], I[1], I[0]. It is the inverse of the receive-side slicer-to-serial converter. It sits between the bit source (PRBS or data input) and the 4-ASK mapper and pulse-shaping filters, so a looped-back stream reproduces the original symbols.

## Interface
- No parameters. Widths are fixed by the shared package.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sam_clk_en  in  1  one-clk-wide enable; exactly one serial bit is consumed per assertion
- serial_in  in  1  serial data bit, sampled only when sam_clk_en=1
- align  in  1  frame-alignment strobe; restarts the bit phase (see Operation)
- sym_I  out  2  assembled I code {I[1], I[0]}
- sym_Q  out  2  assembled Q code {Q[1], Q[0]}
- sym_valid  out  1  one-clk pulse; new sym_I/sym_Q this cycle
- bit_phase  out  2  index of the next bit to be consumed (0 = Q[1])
- map_I, map_Q  out  18 signed 1s17  mapped 4-ASK levels; present only with S2P_LEVEL_MAP_EN

## Operation
- State: bit_cnt (2 bits, 0..3), shift register (3 bits) holding the partial symbol, output registers.
- Each clk edge with sam_clk_en=1 and align=0:
  - store serial_in at position bit_cnt;
  - bit_cnt increments, wrapping from 3 to 0.
- On the edge where bit_cnt==3, sam_clk_en=1 and align=0:
  - sym_Q <= {shift[0] (bit 0), shift[1] (bit 1)};
  - sym_I <= {shift[2] (bit 2), serial_in (bit 3)};
  - sym_valid <= 1.
  - On every other edge sym_valid <= 0.
- sam_clk_en=0: all state holds. sym_I and sym_Q hold their last values indefinitely.
- align=1 with sam_clk_en=1:
  - the bit on this edge is taken as bit 0 (Q[1]);
  - bit_cnt <= 1 and the partial symbol is discarded;
  - no symbol is emitted, even if bit_cnt was 3.
- align=1 with sam_clk_en=0: bit_cnt <= 0 and the partial symbol is discarded.
- bit_phase = bit_cnt (combinational from the register).
- Priority, highest first: reset, then align, then sam_clk_en.

## Timing
- Reset values: bit_cnt=0, shift=0, sym_I=2'b00, sym_Q=2'b00, sym_valid=0, map_I/map_Q=0.
- Latency: the outputs update on the same edge that captures bit 3. sym_valid is high for the clk cycle following that edge.
- Throughput: one symbol per four sam_clk_en pulses. sym_valid never asserts on two consecutive clk cycles.
- Back-to-back enables (sam_clk_en held high) are legal and give one symbol every 4 clk.
- Reset asserted mid-symbol discards the partial bits. The first bit after reset is Q[1].

## Configuration
- S2P_LEVEL_MAP_EN defined:
  - adds registered map_I and map_Q, loaded on the same edge as sym_I and sym_Q;
  - mapping, in 1s17: 00 -> 18'h28000 (-0.75), 01 -> 18'h38000 (-0.25), 10 -> 18'h08000 (+0.25), 11 -> 18'h18000 (+0.75).
- S2P_LEVEL_MAP_EN undefined: map_I and map_Q ports and their logic are absent. Behaviour of all other outputs is identical in both builds.

## Structure
- Shared package (qam16_pkg): SYM_W=2, BITS_PER_SYM=4, LEVEL_W=18, and the four level constants LVL_M3, LVL_M1, LVL_P1, LVL_P3. The receive-side slicer reuses these constants.
- One sub-module: ask4_level_map (combinational 2-bit code -> 18-bit level), instantiated twice under the macro.

## Test plan
- Reset, then serial_in 1,0,0,1 on four sam_clk_en pulses -> sym_Q=2'b10, sym_I=2'b01, sym_valid high exactly one cycle after the 4th edge. With the macro: map_Q=18'h08000, map_I=18'h38000.
- sam_clk_en every 4th clk, stream 0000 1111 -> two sym_valid pulses 16 clk apart; second symbol I=Q=2'b11 (map 18'h18000).
- Two bits sent (1,1), then align with sam_clk_en and bit 0, then 1,1,1 -> one symbol only, Q=2'b01, I=2'b11; no symbol from the discarded pair.
- align with bit_cnt==3 and sam_clk_en=1 -> sym_valid stays 0, bit_phase=1 afterwards.
- Reset asserted after 3 bits, then stream 1,1,0,0 -> sym_Q=2'b11, sym_I=2'b00; outputs read 0 during reset.
- Loopback through the receive-side converter with a random 1000-symbol stream -> recovered I/Q codes match the source exactly.
